// File: rtl/udp_box_writer_if.sv
// Box-writer bus: box descriptors + send request in, byte stream + status out.
// master = request/pop side, slave = the writer itself.
interface udp_box_writer_if #(
   parameter int N_BOX = 1,
   parameter int XW    = 11,
   parameter int YW    = 10
);
   logic                  send;
   logic [N_BOX*XW-1:0]   start_xs;
   logic [N_BOX*YW-1:0]   start_ys;
   logic [N_BOX*XW-1:0]   end_xs;
   logic [N_BOX*YW-1:0]   end_ys;
   logic [N_BOX*24-1:0]   colors;
   logic                  trig;
   logic                  read_en;
   logic [7:0]            tx_data;
   logic [15:0]           tx_data_len;
   logic                  busy;
   logic                  dropped;

   modport master (
      output send, start_xs, start_ys, end_xs, end_ys, colors, read_en,
      input  trig, tx_data, tx_data_len, busy, dropped
   );

   modport slave (
      input  send, start_xs, start_ys, end_xs, end_ys, colors, read_en,
      output trig, tx_data, tx_data_len, busy, dropped
   );
endinterface

// File: rtl/udp_box_writer.sv
// Serializes N_BOX 48-bit box words into a FWFT byte stream for a UDP transmitter.
// trig one cycle after send; bytes pop on read_en; send while busy is dropped.
module udp_box_writer #(
   parameter int N_BOX   = 1,
   parameter int H_ACT   = 1280,
   parameter int V_ACT   = 720,
   parameter int C_DEP   = 2,
   parameter int TIMEOUT = 125_000_000
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   udp_box_writer_if.slave   bus
);
   localparam int XW = $clog2(H_ACT);
   localparam int YW = $clog2(V_ACT);
   localparam int NB = 6 * N_BOX;
   localparam int PW = $clog2(NB + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   localparam logic [PW-1:0] PTR_LAST = PW'(NB - 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   if (2*XW + 2*YW + 3*C_DEP != 48) begin : g_bad_cfg
      $error("udp_box_writer: box fields must pack into exactly 48 bits");
   end

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_SEND = 2'd3
   } state_t;

   state_t          state_q;
   logic [PW-1:0]   ptr_q;
   logic [TW-1:0]   cnt_q;
   logic            trig_q;
   logic            busy_q;
   logic            dropped_q;
   logic [7:0]      shadow_q [NB];
   logic [7:0]      shadow_d [NB];

   // Byte 0 of the packet is the MSB byte of box 0.
   always_comb begin
      logic [47:0] w;
      logic [7:0]  r8, g8, b8;
      w  = '0;
      r8 = '0;
      g8 = '0;
      b8 = '0;
      for (int i = 0; i < NB; i++) shadow_d[i] = '0;
      for (int b = 0; b < N_BOX; b++) begin
         r8 = bus.colors[b*24+16 +: 8];
         g8 = bus.colors[b*24+8  +: 8];
         b8 = bus.colors[b*24    +: 8];
         w  = {bus.start_xs[b*XW +: XW], bus.start_ys[b*YW +: YW],
               bus.end_xs[b*XW +: XW],   bus.end_ys[b*YW +: YW],
               r8[7 -: C_DEP], g8[7 -: C_DEP], b8[7 -: C_DEP]};
         for (int k = 0; k < 6; k++) shadow_d[b*6+k] = w[47-8*k -: 8];
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q   <= ST_IDLE;
         ptr_q     <= '0;
         cnt_q     <= '0;
         trig_q    <= 1'b0;
         busy_q    <= 1'b0;
         dropped_q <= 1'b0;
         for (int i = 0; i < NB; i++) shadow_q[i] <= '0;
      end else begin
         trig_q    <= 1'b0;
         dropped_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (bus.send) begin
                  shadow_q <= shadow_d;
                  ptr_q    <= '0;
                  cnt_q    <= '0;
                  trig_q   <= 1'b1;
                  busy_q   <= 1'b1;
                  state_q  <= ST_REQ;
               end
            end
            ST_REQ: begin
               dropped_q <= bus.send;
               cnt_q     <= '0;
               state_q   <= ST_WAIT;
            end
            ST_WAIT: begin
               dropped_q <= bus.send;
               if (bus.read_en) begin
                  ptr_q   <= ptr_q + PW'(1);
                  state_q <= ST_SEND;
               end else if (cnt_q == TMO_LAST) begin
                  dropped_q <= 1'b1;
                  busy_q    <= 1'b0;
                  state_q   <= ST_IDLE;
               end else begin
                  cnt_q <= cnt_q + TW'(1);
               end
            end
            ST_SEND: begin
               // A send coinciding with the final pop still sees the block busy.
               dropped_q <= bus.send;
               if (bus.read_en) begin
                  ptr_q <= ptr_q + PW'(1);
                  if (ptr_q == PTR_LAST) begin
                     busy_q  <= 1'b0;
                     state_q <= ST_IDLE;
                  end
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   logic showing;
   assign showing = (state_q == ST_WAIT || state_q == ST_SEND) && (ptr_q <= PTR_LAST);

   assign bus.tx_data     = showing ? shadow_q[ptr_q] : 8'h00;
   assign bus.tx_data_len = 16'(NB);
   assign bus.trig        = trig_q;
   assign bus.busy        = busy_q;
   assign bus.dropped     = dropped_q;
endmodule

// File: doc/udp_box_writer.md
UDP_BOX_WRITER -- requirements
Module: udp_box_writer

Interface
REQ-001 Parameter N_BOX, default 1: number of box descriptors serialized per packet.
REQ-002 Parameter H_ACT, default 1280: X coordinate field width is $clog2(H_ACT) (XW).
REQ-003 Parameter V_ACT, default 720: Y coordinate field width is $clog2(V_ACT) (YW).
REQ-004 Parameter C_DEP, default 2: bits kept per colour channel.
REQ-005 Parameter TIMEOUT, default 125_000_000: maximum number of cycles WAIT holds before the first read_en.
REQ-006 Parameter combinations with 2*XW+2*YW+3*C_DEP != 48 SHALL be rejected at elaboration.
REQ-007 clk  in  1  Single clock; all logic is in this domain.
REQ-008 rstn  in  1  Reset, asynchronous assertion, active-low.
REQ-009 send  in  1  Single-cycle request to transmit the current box set.
REQ-010 start_xs  in  N_BOX*XW  Per-box start X; box i occupies slice [i*XW +: XW]; end_xs uses the same layout.
REQ-011 start_ys  in  N_BOX*YW  Per-box start Y; end_ys uses the same layout.
REQ-012 colors  in  N_BOX*24  Per-box RGB888, {R,G,B}; box i occupies slice [i*24 +: 24].
REQ-013 trig  out  1  Single-cycle packet start request to the UDP transmitter.
REQ-014 read_en  in  1  Byte pop from the UDP transmitter.
REQ-015 tx_data  out  8  Current payload byte, first-word-fall-through.
REQ-016 tx_data_len  out  16  Constant value 6*N_BOX.
REQ-017 busy  out  1  High in any state other than IDLE.
REQ-018 dropped  out  1  Single-cycle pulse when a request is lost or a packet times out.

Function
REQ-019 Encoding: each box SHALL be a 48-bit word {sx, sy, ex, ey, R[7-:C_DEP], G[7-:C_DEP], B[7-:C_DEP]}, sent MSB byte first; box 0 is sent first, box N_BOX-1 last.
REQ-020 FSM states: IDLE, REQ, WAIT, SEND.
REQ-021 IDLE + send=1: latch all box inputs into a shadow register, clear the byte pointer, go to REQ; later input changes SHALL NOT affect the packet.
REQ-022 REQ: assert trig for exactly one cycle, then go to WAIT.
REQ-023 WAIT: increment the timeout counter each cycle; the first read_en=1 goes to SEND.
REQ-024 WAIT + counter reaches TIMEOUT-1 with no read_en: go to IDLE and pulse dropped.
REQ-025 tx_data SHALL equal byte[ptr] of the shadow register combinationally in WAIT and SEND, and 8'h00 in IDLE and REQ.
REQ-026 Each cycle with read_en=1 in WAIT or SEND SHALL advance ptr by one; a read_en=0 gap holds ptr and tx_data.
REQ-027 read_en=1 with ptr=6*N_BOX-1 SHALL return to IDLE on the next edge; ptr SHALL never wrap.
REQ-028 read_en in IDLE or REQ SHALL be ignored and SHALL NOT move ptr.
REQ-029 send=1 while busy=1 SHALL be ignored; dropped pulses on the following cycle.
REQ-030 send=1 on the same cycle the FSM returns to IDLE from SEND counts as busy and is dropped.
REQ-031 Pointer width is $clog2(6*N_BOX+1); the timeout counter width is $clog2(TIMEOUT+1).

Reset
REQ-032 rstn=0 SHALL asynchronously force: IDLE, trig=0, busy=0, dropped=0, tx_data=8'h00, ptr=0, timeout counter=0, shadow register=0.
REQ-033 Reset mid-packet SHALL abandon the packet without a dropped pulse; after release, the first send starts a fresh packet from byte 0.

Verification
REQ-034 N_BOX=1, sx=100, sy=50, ex=200, ey=150, colors=24'hFF0000, send pulse:
  - trig is high for one cycle, 1 cycle after send.
  - 6 consecutive read_en cycles yield 0C 81 90 C8 25 B0.
  - busy falls after the last read_en.
REQ-035 Same packet with read_en low for 3 cycles after byte 2: byte 2 (0x90) is held through the gap; the bytes still arrive in order 0C 81 90 C8 25 B0.
REQ-036 TIMEOUT=16, send with no read_en:
  - busy stays high for 1+16 cycles.
  - dropped pulses once; FSM returns to IDLE.
  - tx_data=00 afterwards.
REQ-037 send during SEND: dropped pulses once; the in-flight bytes are unchanged. Inputs changed after send do not alter the packet.
REQ-038 N_BOX=2: 12 bytes; box 0 bytes precede box 1 bytes; tx_data_len=12.
REQ-039 rstn pulsed low after byte 3:
  - all outputs reset immediately, with no dropped pulse.
  - a new send produces the full packet from 0x0C.
